ctrl_fsm: RTL and testbench
===========================

CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 SHALL have parameter n, default 8: data/immediate width.
REQ-002 SHALL have parameter PW, default 8: program counter width.
REQ-003 SHALL have ports:
- clk  input  1  system clock; all state changes on its rising edge.
- nReset  input  1  asynchronous, active-low reset.
- instr  input  16  instruction word from program memory, valid the cycle after pc changes.
- switches  input  9  external switches; switches[8] is the operator handshake.
- alu_flags  input  4  ALU flags {V,N,Z,C}.
- pc  output  PW  program counter.
- alu_func  output  3  ALU function code.
- a_sel  output  2  ALU A-input select.
- b_sel  output  2  ALU B-input select.
- imm  output  1  selects immediate onto ALU B.
- immediate  output  n  instr[7:0].
- rd_addr  output  2  destination register, instr[11:10].
- rs_addr  output  2  source register, instr[9:8].
- reg_we  output  1  register-file write enable.
- flags_q  output  4  latched {V,N,Z,C}.
- illegal  output  1  one-cycle pulse on an undefined opcode.

Function
REQ-004 SHALL implement FSM states FETCH, EXEC, WAIT_HI and WAIT_LO.
- FETCH->EXEC is unconditional, one cycle.
REQ-005 SHALL decode opcode instr[15:12] in EXEC as follows:
- 0 NOP.
- 1 ADD: RADD, REG/REG.
- 2 ADDI: RADD, imm=1.
- 3 SUB: RSUB.
- 4 SUBI: RSUB, imm=1.
- 5 MULL: RMULL.
- 6 MULLI: RMULL, imm=1.
- 7 MOV: RB.
- 8 MOVI: RB, imm=1.
- 9 LDSW: RA, a_sel=SW_7_0.
- A WAIT.
- B BEQ.
- C BNE.
- D JMP.
- E-F illegal.
REQ-006 SHALL drive alu_func=RA, a_sel=b_sel=REG, imm=0, reg_we=0 in every state other than EXEC and for NOP, WAIT, BEQ, BNE, JMP and illegal opcodes.
REQ-007 SHALL assert reg_we for exactly one cycle, the EXEC cycle, for opcodes 1-9.
REQ-008 SHALL load flags_q<=alu_flags at the end of EXEC for opcodes 1-6 only; all other opcodes hold flags_q.
REQ-009 SHALL update pc at the end of EXEC:
- BEQ with flags_q[1]=1, or BNE with flags_q[1]=0: pc <= pc + sign-extended instr[7:0], truncated to PW bits.
- JMP: pc <= instr[PW-1:0].
- WAIT: pc holds.
- All other opcodes: pc <= pc+1.
REQ-010 SHALL use the flags_q value held before the current instruction when evaluating branches.
REQ-011 SHALL wrap pc modulo 2^PW; 255+1=0 and 0-1=255 for PW=8.
REQ-012 SHALL move EXEC->WAIT_HI on WAIT.
- WAIT_HI holds until switches[8]=1, then moves to WAIT_LO.
- WAIT_LO holds until switches[8]=0, then pc<=pc+1 and the state moves to FETCH.
REQ-013 SHALL, when switches[8] is already 1 on entry to WAIT_HI, move to WAIT_LO on the next cycle.
REQ-014 SHALL pulse illegal for the EXEC cycle of opcodes E-F; these execute as NOP with pc+1.
REQ-015 SHALL always drive immediate, rd_addr and rs_addr directly from instr fields, without gating.

Reset
REQ-016 SHALL, while nReset=0, asynchronously force: state=FETCH, pc=0, flags_q=0, reg_we=0, illegal=0, alu_func=RA, sels=REG, imm=0.
REQ-017 SHALL abandon any instruction or wait in progress on reset, with no register write or flag update.
REQ-018 SHALL, after nReset deasserts, spend one FETCH cycle at pc=0 before the first EXEC.

Structure
REQ-019 SHALL take ALU function codes (RA=000, RB=001, RADD=010, RSUB=011, RMULL=100), select codes (REG=00, SW_7_0=01, SW_8=10), the opcode enum and the FSM state enum from shared package pico_pkg, also used by the ALU.
REQ-020 SHALL keep the purely combinational opcode-to-control decode in sub-module op_decode; ctrl_fsm holds the state, pc and flags_q.

Verification
REQ-021 SHALL cover reset: assert nReset mid-WAIT_LO -> pc=0, state FETCH, flags_q=0 immediately, without waiting for clk.
REQ-022 SHALL cover ADDI: instr=0x2412 -> EXEC shows alu_func=010, imm=1, immediate=0x12, rd_addr=1, reg_we=1 for one cycle; pc 0->1.
REQ-023 SHALL cover branches:
- SUB with alu_flags=0010 then BEQ imm=0xFE at pc=5 -> pc=3.
- Same sequence with BNE -> pc=6.
REQ-024 SHALL cover WAIT: hold switches[8]=0 for 10 cycles -> pc frozen; raise for 3 cycles -> still frozen; drop -> pc+1 next cycle.
REQ-025 SHALL cover wrap and JMP: ADD at pc=255 -> pc=0; JMP 0x40 -> pc=0x40, flags_q unchanged.
REQ-026 SHALL cover illegal opcode: instr=0xF000 -> illegal=1 for one cycle, reg_we=0, pc+1.

Source files
------------

// File: rtl/pico_pkg.sv
// Shared encodings for the pico CPU: ALU function codes, operand selects, opcodes, FSM states.
package pico_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned FUNC_W = 3;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [FUNC_W-1:0] {
    RA    = 3'b000,
    RB    = 3'b001,
    RADD  = 3'b010,
    RSUB  = 3'b011,
    RMULL = 3'b100
  } alu_func_e;

  typedef enum logic [SEL_W-1:0] {
    REG    = 2'b00,
    SW_7_0 = 2'b01,
    SW_8   = 2'b10
  } sel_e;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_ADDI  = 4'h2,
    OP_SUB   = 4'h3,
    OP_SUBI  = 4'h4,
    OP_MULL  = 4'h5,
    OP_MULLI = 4'h6,
    OP_MOV   = 4'h7,
    OP_MOVI  = 4'h8,
    OP_LDSW  = 4'h9,
    OP_WAIT  = 4'hA,
    OP_BEQ   = 4'hB,
    OP_BNE   = 4'hC,
    OP_JMP   = 4'hD,
    OP_ILL_E = 4'hE,
    OP_ILL_F = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    EXEC    = 2'b01,
    WAIT_HI = 2'b10,
    WAIT_LO = 2'b11
  } state_e;

  // Datapath controls produced by the opcode decoder
  typedef struct packed {
    alu_func_e alu_func;
    sel_e      a_sel;
    sel_e      b_sel;
    logic      imm;
    logic      reg_we;
    logic      flag_we;
    logic      illegal;
  } ctrl_t;

endpackage

// File: rtl/op_decode.sv
// Purely combinational opcode-to-control decode.
module op_decode
  import pico_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output ctrl_t           ctrl_c
);

  // Map each opcode to its ALU function, operand selects and write/flag enables
  always_comb begin
    ctrl_c = '{alu_func: RA, a_sel: REG, b_sel: REG, imm: 1'b0,
               reg_we: 1'b0, flag_we: 1'b0, illegal: 1'b0};
    case (opcode_e'(opcode))
      OP_ADD:   begin ctrl_c.alu_func = RADD;  ctrl_c.reg_we = 1'b1; ctrl_c.flag_we = 1'b1; end
      OP_ADDI:  begin ctrl_c.alu_func = RADD;  ctrl_c.imm = 1'b1; ctrl_c.reg_we = 1'b1; ctrl_c.flag_we = 1'b1; end
      OP_SUB:   begin ctrl_c.alu_func = RSUB;  ctrl_c.reg_we = 1'b1; ctrl_c.flag_we = 1'b1; end
      OP_SUBI:  begin ctrl_c.alu_func = RSUB;  ctrl_c.imm = 1'b1; ctrl_c.reg_we = 1'b1; ctrl_c.flag_we = 1'b1; end
      OP_MULL:  begin ctrl_c.alu_func = RMULL; ctrl_c.reg_we = 1'b1; ctrl_c.flag_we = 1'b1; end
      OP_MULLI: begin ctrl_c.alu_func = RMULL; ctrl_c.imm = 1'b1; ctrl_c.reg_we = 1'b1; ctrl_c.flag_we = 1'b1; end
      OP_MOV:   begin ctrl_c.alu_func = RB;    ctrl_c.reg_we = 1'b1; end
      OP_MOVI:  begin ctrl_c.alu_func = RB;    ctrl_c.imm = 1'b1; ctrl_c.reg_we = 1'b1; end
      OP_LDSW:  begin ctrl_c.alu_func = RA;    ctrl_c.a_sel = SW_7_0; ctrl_c.reg_we = 1'b1; end
      OP_ILL_E,
      OP_ILL_F: ctrl_c.illegal = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Pico CPU control unit: fetch/execute sequencing, program counter, latched ALU flags.
module ctrl_fsm
  import pico_pkg::*;
#(
  parameter int unsigned n  = 8,
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic [15:0]   instr,
  input  logic [8:0]    switches,
  input  logic [3:0]    alu_flags,
  output logic [PW-1:0] pc,
  output logic [2:0]    alu_func,
  output logic [1:0]    a_sel,
  output logic [1:0]    b_sel,
  output logic          imm,
  output logic [n-1:0]  immediate,
  output logic [1:0]    rd_addr,
  output logic [1:0]    rs_addr,
  output logic          reg_we,
  output logic [3:0]    flags_q,
  output logic          illegal
);

  state_e        state;
  ctrl_t         dec_c;
  opcode_e       op_c;
  logic [PW-1:0] br_off_c;
  logic [PW-1:0] pc_next_c;
  logic          unused_sw_c;

  op_decode u_op_decode (
    .opcode (instr[15:12]),
    .ctrl_c (dec_c)
  );

  // Instruction fields go straight to the datapath
  assign immediate   = n'(instr[7:0]);
  assign rd_addr     = instr[11:10];
  assign rs_addr     = instr[9:8];
  assign op_c        = opcode_e'(instr[15:12]);
  assign unused_sw_c = ^switches[7:0];

  // Next pc at the end of EXEC; branches test the flags latched by earlier instructions
  always_comb begin
    br_off_c  = PW'($signed(instr[7:0]));
    pc_next_c = pc + PW'(1);
    case (op_c)
      OP_BEQ:  if (flags_q[1])  pc_next_c = pc + br_off_c;
      OP_BNE:  if (!flags_q[1]) pc_next_c = pc + br_off_c;
      OP_JMP:  pc_next_c = instr[PW-1:0];
      OP_WAIT: pc_next_c = pc;
      default: ;
    endcase
  end

  // Sequencer: controls are registered in FETCH so they are valid for exactly the EXEC cycle
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state    <= FETCH;
      pc       <= '0;
      flags_q  <= '0;
      alu_func <= RA;
      a_sel    <= REG;
      b_sel    <= REG;
      imm      <= 1'b0;
      reg_we   <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          state    <= EXEC;
          alu_func <= dec_c.alu_func;
          a_sel    <= dec_c.a_sel;
          b_sel    <= dec_c.b_sel;
          imm      <= dec_c.imm;
          reg_we   <= dec_c.reg_we;
          illegal  <= dec_c.illegal;
        end
        EXEC: begin
          alu_func <= RA;
          a_sel    <= REG;
          b_sel    <= REG;
          imm      <= 1'b0;
          reg_we   <= 1'b0;
          illegal  <= 1'b0;
          if (dec_c.flag_we) flags_q <= alu_flags;
          pc       <= pc_next_c;
          state    <= (op_c == OP_WAIT) ? WAIT_HI : FETCH;
        end
        WAIT_HI: begin
          if (switches[8]) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!switches[8]) begin
            pc    <= pc + PW'(1);
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Directed bench for ctrl_fsm with an instruction-level reference model checked every cycle.
module tb_ctrl_fsm;

  localparam int unsigned N  = 8;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          nReset;
  logic [15:0]   instr;
  logic [8:0]    switches;
  logic [3:0]    alu_flags;
  logic [PW-1:0] pc;
  logic [2:0]    alu_func;
  logic [1:0]    a_sel;
  logic [1:0]    b_sel;
  logic          imm;
  logic [N-1:0]  immediate;
  logic [1:0]    rd_addr;
  logic [1:0]    rs_addr;
  logic          reg_we;
  logic [3:0]    flags_q;
  logic          illegal;

  ctrl_fsm #(.n(N), .PW(PW)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .instr     (instr),
    .switches  (switches),
    .alu_flags (alu_flags),
    .pc        (pc),
    .alu_func  (alu_func),
    .a_sel     (a_sel),
    .b_sel     (b_sel),
    .imm       (imm),
    .immediate (immediate),
    .rd_addr   (rd_addr),
    .rs_addr   (rs_addr),
    .reg_we    (reg_we),
    .flags_q   (flags_q),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;

  // Reference model state: architectural pc/flags and expected controls for the current cycle
  logic [7:0] m_pc;
  logic [3:0] m_flags;
  logic [2:0] e_func;
  logic [1:0] e_asel;
  logic       e_imm;
  logic       e_we;
  logic       e_ill;

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic set_idle();
    e_func = 3'b000; e_asel = 2'b00; e_imm = 1'b0; e_we = 1'b0; e_ill = 1'b0;
  endtask

  // Controls an instruction must present during its execute cycle
  task automatic set_exec(input logic [15:0] w);
    logic [3:0] op;
    op = w[15:12];
    set_idle();
    case (op)
      4'h1, 4'h2: e_func = 3'b010;
      4'h3, 4'h4: e_func = 3'b011;
      4'h5, 4'h6: e_func = 3'b100;
      4'h7, 4'h8: e_func = 3'b001;
      default:    e_func = 3'b000;
    endcase
    e_imm  = (op == 4'h2) || (op == 4'h4) || (op == 4'h6) || (op == 4'h8);
    e_we   = (op >= 4'h1) && (op <= 4'h9);
    e_asel = (op == 4'h9) ? 2'b01 : 2'b00;
    e_ill  = (op >= 4'hE);
  endtask

  // Architectural effect of retiring one instruction
  task automatic retire(input logic [15:0] w, input logic [3:0] f);
    logic [3:0] op;
    op = w[15:12];
    if ((op == 4'hB && m_flags[1]) || (op == 4'hC && !m_flags[1])) m_pc = m_pc + w[7:0];
    else if (op == 4'hD) m_pc = w[7:0];
    else if (op != 4'hA) m_pc = m_pc + 8'd1;
    if (op >= 4'h1 && op <= 4'h6) m_flags = f;
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc",        16'(pc),        16'(m_pc));
      chk("flags_q",   16'(flags_q),   16'(m_flags));
      chk("alu_func",  16'(alu_func),  16'(e_func));
      chk("a_sel",     16'(a_sel),     16'(e_asel));
      chk("b_sel",     16'(b_sel),     16'(2'b00));
      chk("imm",       16'(imm),       16'(e_imm));
      chk("reg_we",    16'(reg_we),    16'(e_we));
      chk("illegal",   16'(illegal),   16'(e_ill));
      chk("immediate", 16'(immediate), 16'(instr[7:0]));
      chk("rd_addr",   16'(rd_addr),   16'(instr[11:10]));
      chk("rs_addr",   16'(rs_addr),   16'(instr[9:8]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exec_begin(input logic [15:0] w, input logic [3:0] f);
    instr = w; alu_flags = f; set_idle();
    step();
    set_exec(w);
  endtask

  task automatic exec_end(input logic [15:0] w, input logic [3:0] f);
    step();
    retire(w, f);
    set_idle();
  endtask

  task automatic exec(input logic [15:0] w, input logic [3:0] f);
    exec_begin(w, f);
    exec_end(w, f);
  endtask

  initial begin
    nReset = 1'b0; instr = 16'h0000; switches = 9'h000; alu_flags = 4'h0;
    m_pc = 8'h00; m_flags = 4'h0; set_idle();
    #1;
    chk("rst_pc",     16'(pc),       16'h0000);
    chk("rst_flags",  16'(flags_q),  16'h0000);
    chk("rst_we",     16'(reg_we),   16'h0000);
    chk("rst_func",   16'(alu_func), 16'h0000);
    step(); step();
    nReset = 1'b1;
    chk_en = 1'b1;

    // ADDI r1, 0x12
    exec_begin(16'h2412, 4'b0101);
    chk("addi_func", 16'(alu_func),  16'h0002);
    chk("addi_imm",  16'(imm),       16'h0001);
    chk("addi_val",  16'(immediate), 16'h0012);
    chk("addi_rd",   16'(rd_addr),   16'h0001);
    chk("addi_we",   16'(reg_we),    16'h0001);
    exec_end(16'h2412, 4'b0101);
    chk("addi_pc",     16'(pc),      16'h0001);
    chk("addi_we_off", 16'(reg_we),  16'h0000);
    chk("addi_flags",  16'(flags_q), 16'h0005);

    // Branch taken backwards: SUB sets Z, BEQ -2 at pc=5
    repeat (3) exec(16'h0000, 4'h0);
    exec(16'h3100, 4'b0010);
    chk("sub_pc", 16'(pc), 16'h0005);
    exec(16'hB0FE, 4'b1111);
    chk("beq_pc",    16'(pc),      16'h0003);
    chk("beq_flags", 16'(flags_q), 16'h0002);

    // Same sequence with BNE falls through; then BNE taken forward
    exec(16'h0000, 4'h0);
    exec(16'h3100, 4'b0010);
    exec(16'hC0FE, 4'h0);
    chk("bne_nt_pc", 16'(pc), 16'h0006);
    exec(16'h3100, 4'b1000);
    exec(16'hC002, 4'h0);
    chk("bne_t_pc", 16'(pc), 16'h0009);

    // WAIT handshake; low switch bits must not matter
    exec(16'hA000, 4'h0);
    switches = 9'h0A5;
    repeat (10) step();
    chk("wait_lo_hold", 16'(pc), 16'h0009);
    switches[8] = 1'b1;
    repeat (3) step();
    chk("wait_hi_hold", 16'(pc), 16'h0009);
    switches[8] = 1'b0;
    step();
    m_pc = m_pc + 8'd1;
    chk("wait_done_pc", 16'(pc), 16'h000A);

    // WAIT entered with handshake already high, then reset mid-WAIT_LO
    switches[8] = 1'b1;
    exec(16'hA000, 4'h0);
    step();
    #2;
    chk_en = 1'b0;
    nReset = 1'b0;
    #1;
    chk("arst_pc",    16'(pc),      16'h0000);
    chk("arst_flags", 16'(flags_q), 16'h0000);
    chk("arst_we",    16'(reg_we),  16'h0000);
    chk("arst_ill",   16'(illegal), 16'h0000);
    instr = 16'h0000; switches = 9'h000;
    m_pc = 8'h00; m_flags = 4'h0; set_idle();
    step();
    chk("arst_hold_pc", 16'(pc), 16'h0000);
    nReset = 1'b1;
    chk_en = 1'b1;

    // Wrap and jumps; flags survive non-ALU opcodes
    exec(16'h2306, 4'b0110);
    chk("post_rst_pc", 16'(pc), 16'h0001);
    exec(16'hD0FF, 4'h0);
    chk("jmp_ff_pc",    16'(pc),      16'h00FF);
    chk("jmp_ff_flags", 16'(flags_q), 16'h0006);
    exec(16'h1000, 4'b0011);
    chk("wrap_pc", 16'(pc), 16'h0000);
    exec(16'hB0FF, 4'h0);
    chk("wrap_back_pc", 16'(pc), 16'h00FF);
    exec(16'hD040, 4'b1111);
    chk("jmp_40_pc",    16'(pc),      16'h0040);
    chk("jmp_40_flags", 16'(flags_q), 16'h0003);

    // Illegal opcodes act as NOP with a one-cycle pulse
    exec_begin(16'hF000, 4'b1111);
    chk("ill_pulse", 16'(illegal), 16'h0001);
    chk("ill_we",    16'(reg_we),  16'h0000);
    exec_end(16'hF000, 4'b1111);
    chk("ill_off",   16'(illegal), 16'h0000);
    chk("ill_pc",    16'(pc),      16'h0041);
    chk("ill_flags", 16'(flags_q), 16'h0003);
    exec(16'hE123, 4'h0);

    // Remaining data opcodes
    exec(16'h4501, 4'b0001);
    exec(16'h5600, 4'b1001);
    exec(16'h6B07, 4'b0100);
    exec(16'h7300, 4'b1111);
    exec_begin(16'h8AFF, 4'b1111);
    chk("movi_imm", 16'(imm), 16'h0001);
    exec_end(16'h8AFF, 4'b1111);
    exec_begin(16'h9C00, 4'b1111);
    chk("ldsw_asel", 16'(a_sel), 16'h0001);
    exec_end(16'h9C00, 4'b1111);
    chk("final_pc",    16'(pc),      16'h0048);
    chk("final_flags", 16'(flags_q), 16'h0004);

    step();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
